// File: rtl/hermes_flit_tx.sv
// hermes_flit_tx: credit-based serialiser of header, size and payload flits into a Hermes router input port.
module hermes_flit_tx #(
  parameter int FLIT_SIZE = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [FLIT_SIZE-1:0] header_i,
  input  logic [FLIT_SIZE-1:0] size_i,
  output logic                 ready_o,
  output logic                 err_o,
  input  logic                 pl_valid_i,
  input  logic [FLIT_SIZE-1:0] pl_data_i,
  output logic                 pl_ready_o,
  output logic                 rx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o
);
  typedef enum logic [2:0] {IDLE, HEADER, SIZE, PAYLOAD, DONE} state_t;
  state_t state, state_n;
  logic [FLIT_SIZE-1:0] hdr_q, size_q, rem_q;
  logic zero_size, accept;
  assign zero_size = size_i == '0;
  assign accept = ready_o && start_i && !zero_size;
  assign ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      hdr_q <= '0;
      size_q <= '0;
      rem_q <= '0;
      pkt_cnt_o <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      err_o <= ready_o && start_i && zero_size;
      if (accept) begin
        hdr_q <= header_i;
        size_q <= size_i;
        rem_q <= size_i;
      end
      if (state == PAYLOAD && rx_o) rem_q <= rem_q - 1'b1;
      if (done_o) pkt_cnt_o <= pkt_cnt_o + 1'b1;
    end
  end
  // Router-side outputs depend only on state, credit and payload handshake, never on start_i.
  always_comb begin
    state_n = state;
    rx_o = 1'b0;
    data_o = '0;
    pl_ready_o = 1'b0;
    case (state)
      IDLE: state_n = accept ? HEADER : IDLE;
      HEADER: begin
        data_o = hdr_q;
        rx_o = credit_i;
        state_n = credit_i ? SIZE : HEADER;
      end
      SIZE: begin
        data_o = size_q;
        rx_o = credit_i;
        state_n = credit_i ? PAYLOAD : SIZE;
      end
      PAYLOAD: begin
        data_o = pl_data_i;
        rx_o = pl_valid_i && credit_i;
        pl_ready_o = rx_o;
        state_n = (rx_o && rem_q == FLIT_SIZE'(1)) ? DONE : PAYLOAD;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hermes_flit_tx.sv
// tb_hermes_flit_tx: scoreboard bench for hermes_flit_tx with directed and randomised packets.
module tb_hermes_flit_tx;
  localparam int FW = 32;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst_i = 1'b1, start_i = 1'b0, pl_valid_i = 1'b0, credit_i = 1'b1;
  logic [FW-1:0] header_i = '0, size_i = '0, pl_data_i = '0;
  logic ready_o, err_o, pl_ready_o, rx_o, done_o, busy_o;
  logic [FW-1:0] data_o;
  logic [CW-1:0] pkt_cnt_o;
  int checks = 0, failures = 0;
  logic [FW-1:0] exp_q[$], pl_q[$];
  int cnt_model = 0, pl_seen = 0, cyc = 0;
  int cred_pct = 100, val_pct = 100, stall_lo = -1, stall_hi = -1;
  bit cnt_pend = 0, tog = 0;

  hermes_flit_tx #(.FLIT_SIZE(FW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .header_i(header_i), .size_i(size_i),
    .ready_o(ready_o), .err_o(err_o), .pl_valid_i(pl_valid_i), .pl_data_i(pl_data_i),
    .pl_ready_o(pl_ready_o), .rx_o(rx_o), .data_o(data_o), .credit_i(credit_i),
    .done_o(done_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer is checked against the expected flit stream in order.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (cnt_pend) begin
        chk("pkt_cnt", 64'(pkt_cnt_o), 64'(cnt_model));
        cnt_pend = 0;
      end
      if (rx_o && !credit_i) chk("rx_without_credit", 64'(rx_o), 64'd0);
      if (pl_ready_o && !(rx_o && pl_valid_i)) chk("pl_ready_without_transfer", 64'(pl_ready_o), 64'd0);
      if (rx_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_flit: got %0h expected no transfer", data_o);
        end else chk("flit", 64'(data_o), 64'(exp_q.pop_front()));
        if (pl_ready_o) begin
          pl_seen++;
          if (pl_q.size() > 0) void'(pl_q.pop_front());
        end
      end
      if (done_o) begin
        chk("done_after_all_flits", 64'(exp_q.size()), 64'd0);
        cnt_model = (cnt_model + 1) % (1 << CW);
        cnt_pend = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    start_i = 1'b0;
    header_i = $urandom;
    size_i = $urandom;
    credit_i = (cyc >= stall_lo && cyc <= stall_hi) ? 1'b0 : ($urandom_range(99) < cred_pct);
    pl_valid_i = pl_q.size() > 0 && (tog ? (cyc % 2 == 1) : ($urandom_range(99) < val_pct));
    pl_data_i = pl_q.size() > 0 ? pl_q[0] : $urandom;
  endtask

  task automatic start_pkt(input logic [FW-1:0] hdr, input int n);
    logic [FW-1:0] d;
    header_i = hdr;
    size_i = FW'(n);
    start_i = 1'b1;
    exp_q.push_back(hdr);
    exp_q.push_back(FW'(n));
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      pl_q.push_back(d);
      exp_q.push_back(d);
    end
    cyc = 0;
  endtask

  task automatic run_pkt(input int n, input int exp_cyc, input bit spur);
    bit got = 0;
    for (int c = 1; c <= 20 * (n + 3) + 50 && !got; c++) begin
      step();
      if (spur && cyc <= n + 2 && $urandom_range(3) == 0) begin
        start_i = 1'b1;
        size_i = FW'($urandom_range(5));
      end
      @(negedge clk);
      chk("busy_during_packet", 64'(busy_o), 64'd1);
      chk("no_err_during_packet", 64'(err_o), 64'd0);
      if (done_o) got = 1;
    end
    chk("done_seen", 64'(got), 64'd1);
    if (got && exp_cyc > 0) chk("done_cycle", 64'(cyc), 64'(exp_cyc));
    step();
    @(negedge clk);
    chk("ready_after_done", 64'(ready_o), 64'd1);
    chk("single_done", 64'(done_o), 64'd0);
  endtask

  task automatic send(input logic [FW-1:0] hdr, input int n, input int exp_cyc, input bit spur);
    step();
    start_pkt(hdr, n);
    run_pkt(n, exp_cyc, spur);
  endtask

  task automatic zero_start();
    step();
    size_i = '0;
    start_i = 1'b1;
    step();
    @(negedge clk);
    chk("err_pulse", 64'(err_o), 64'd1);
    chk("ready_after_err", 64'(ready_o), 64'd1);
    chk("no_rx_after_err", 64'(rx_o), 64'd0);
    step();
    @(negedge clk);
    chk("err_one_cycle", 64'(err_o), 64'd0);
    chk("idle_after_err", 64'(busy_o), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    pl_q.delete();
    pl_valid_i = 1'b0;
    cnt_model = 0;
    cnt_pend = 0;
    @(negedge clk);
    chk("rst_rx", 64'(rx_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_pl_ready", 64'(pl_ready_o), 64'd0);
  endtask

  initial begin
    int p0;
    bit seen;
    do_reset();
    send(32'h0000_0102, 3, 6, 0);
    stall_lo = 2;
    stall_hi = 4;
    send(32'h0000_0102, 3, 9, 0);
    stall_lo = -1;
    stall_hi = -1;
    tog = 1;
    send(32'h0000_0a0b, 2, 6, 0);
    tog = 0;
    zero_start();
    send(32'h0000_0c0d, 4, 0, 1);
    step();
    start_pkt(32'h0000_0e0f, 4);
    p0 = pl_seen;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      step();
      @(negedge clk);
      #1;
      if (pl_seen > p0) seen = 1;
    end
    chk("first_payload_before_reset", 64'(seen), 64'd1);
    do_reset();
    send(32'h0000_1111, 1, 4, 0);
    do_reset();
    for (int i = 0; i < 5; i++) send($urandom, 1, 4, 0);
    cred_pct = 70;
    val_pct = 70;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(4) == 0) zero_start();
      send($urandom, int'($urandom_range(1, 6)), 0, 1);
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hermes_flit_tx.md
# hermes_flit_tx

Credit-based packet transmitter that drives a Hermes router input port: it serialises one packet at a time as header flit, size flit and payload flits onto the port's rx/data/credit interface. It sits in the local network interface between the packet source (DMA or processing element) and the router's local input buffer, and is the producer counterpart of that buffer's write side. It packs a packet command plus a payload stream into the exact flit sequence the buffer's send FSM expects, where the size flit gives the payload flit count.

## Interface
- FLIT_SIZE, 32, flit width in bits (minimum 20).
- CNT_WIDTH, 16, width of the sent-packet counter.

- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  packet command valid; sampled only while ready_o=1.
- header_i  in  FLIT_SIZE  header flit (target address), captured on start.
- size_i  in  FLIT_SIZE  payload flit count, captured on start; must be ≥1.
- ready_o  out  1  transmitter idle, command accepted this cycle if start_i=1.
- err_o  out  1  one-cycle pulse: start_i with size_i==0 rejected.
- pl_valid_i  in  1  payload flit valid.
- pl_data_i  in  FLIT_SIZE  payload flit.
- pl_ready_o  out  1  payload flit consumed this cycle.
- rx_o  out  1  flit transfer to router input; high only when credit_i=1.
- data_o  out  FLIT_SIZE  flit presented to router.
- credit_i  in  1  router buffer has space (not full).
- done_o  out  1  one-cycle pulse after last payload flit transferred.
- busy_o  out  1  packet in progress (state ≠ IDLE).
- pkt_cnt_o  out  CNT_WIDTH  packets completed since reset, wraps modulo 2^CNT_WIDTH.

## Operation
- FSM states: IDLE, HEADER, SIZE, PAYLOAD, DONE (one-hot or binary, implementer's choice).
- IDLE: ready_o=1. start_i && size_i≠0 → capture header_i, size_i into registers, remaining count ← size_i; → HEADER. start_i && size_i==0 → err_o pulse next cycle, stay IDLE, nothing captured.
- HEADER: data_o=header reg, rx_o=credit_i; on rx_o → SIZE.
- SIZE: data_o=size reg, rx_o=credit_i; on rx_o → PAYLOAD.
- PAYLOAD: data_o=pl_data_i, rx_o=pl_valid_i && credit_i, pl_ready_o=rx_o; each transfer decrements remaining count; transfer with count==1 → DONE.
- DONE: done_o=1, pkt_cnt_o increments (registered, visible next cycle); → IDLE unconditionally.
- A flit transfers exactly on a cycle where rx_o=1; rx_o never asserted with credit_i=0. No data_o stability requirement when rx_o=0 outside PAYLOAD, except data_o=0 in IDLE and DONE.
- Count arithmetic FLIT_SIZE bits, unsigned; full range 1..2^FLIT_SIZE−1 supported.
- Payload flits are not buffered internally; backpressure passes through combinationally (credit_i → pl_ready_o).

## Timing
- Reset (rst_i=1 at edge): state IDLE, count 0, pkt_cnt_o 0; outputs next cycle: ready_o=1, rx_o=0, data_o=0, pl_ready_o=0, done_o=0, err_o=0, busy_o=0.
- Reset mid-packet: packet abandoned at next edge, no done_o, pkt_cnt_o cleared; system guarantees router reset alongside.
- Latency, no stalls, N payload flits: start at cycle 0 → header cycle 1, size cycle 2, payload cycles 3..N+2, done_o cycle N+3, ready_o cycle N+4. Throughput one flit/cycle.
- credit_i low for k cycles in any flit state extends that state by k cycles; flit held, not dropped or duplicated.
- rx_o, pl_ready_o combinational from state, credit_i, pl_valid_i; no combinational path from start_i to any router-side output.
- start_i ignored while busy_o=1 (no queuing).
- pkt_cnt_o wraps 2^CNT_WIDTH−1 → 0 without error.

## Test plan
- Reset then start header=0x0000_0102, size=3, payload A,B,C, credit_i=1 → data_o sequence 0x102,3,A,B,C on cycles 1..5, done_o cycle 6, pkt_cnt_o=1.
- Same packet, credit_i=0 during cycles 2–4 → size flit held 3 cycles, rx_o=0 throughout, sequence unchanged, done_o at cycle 9.
- pl_valid_i toggling 1,0,1,0 in PAYLOAD with size=2 → rx_o/pl_ready_o follow pl_valid_i, exactly 2 payload transfers, done_o once.
- start_i with size_i=0 → err_o pulse, ready_o stays 1, rx_o never asserted; start_i during busy ignored, no second packet.
- rst_i asserted in PAYLOAD after 1 of 4 flits → rx_o=0 next cycle, ready_o=1, pkt_cnt_o=0, new packet size=1 then sends correctly.
- CNT_WIDTH=2, send 5 packets size=1 → pkt_cnt_o 1,2,3,0,1.
